instr_sequencer: RTL and testbench

Sits between the line decoder and the light-grid brightness datapath. It buffers normalized instructions in a small FIFO and walks each instruction's rectangle row-major, one cell per cycle, driving a valid/ready cell-update stream. It also tracks end of file and raises a sticky done once every buffered instruction has been fully issued.

---
 rtl/instr_sequencer.sv | 172 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction FIFO plus row-major rectangle walker driving a cell-update stream
// Optional build macro INSTR_SEQ_STATS_EN adds saturating instr_count/cell_count outputs.
module instr_sequencer #(
    parameter int POSITION_WIDTH    = 12,
    parameter int INSTRUCTION_WIDTH = 50,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         end_of_file,
    input  logic                         normalized_instr_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] normalized_instr_data,
    output logic                         cell_valid,
    input  logic                         cell_ready,
    output logic [POSITION_WIDTH-1:0]    cell_row,
    output logic [POSITION_WIDTH-1:0]    cell_col,
    output logic [1:0]                   cell_op,
    output logic                         cell_last,
    output logic                         done,
    output logic                         overflow
`ifdef INSTR_SEQ_STATS_EN
    ,
    output logic [31:0]                  instr_count,
    output logic [31:0]                  cell_count
`endif
);
    localparam int PW = POSITION_WIDTH;
    localparam int IW = INSTRUCTION_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [PW-1:0] POS_ONE = PW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [IW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          eof_q, overflow_q;
    logic [1:0]    op_q, op_d;
    logic [PW-1:0] row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
    logic [PW-1:0] row_hi_q, row_hi_d, col_lo_q, col_lo_d, col_hi_q, col_hi_d;

    logic          full, empty, push, pop, scan_last, handshake;
    logic [IW-1:0] head;
    logic [1:0]    head_op;
    logic [PW-1:0] h_sr, h_sc, h_er, h_ec;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = normalized_instr_valid && !full && !done;
    assign pop   = (state_q == ST_LOAD);

    assign head    = mem_q[rd_ptr_q];
    assign head_op = head[IW-1 -: 2];
    assign h_sr    = head[4*PW-1 -: PW];
    assign h_sc    = head[3*PW-1 -: PW];
    assign h_er    = head[2*PW-1 -: PW];
    assign h_ec    = head[PW-1:0];

    assign scan_last  = (row_cnt_q == row_hi_q) && (col_cnt_q == col_hi_q);
    assign cell_valid = (state_q == ST_SCAN);
    assign cell_last  = cell_valid && scan_last;
    assign cell_row   = row_cnt_q;
    assign cell_col   = col_cnt_q;
    assign cell_op    = op_q;
    assign done       = (state_q == ST_DONE);
    assign overflow   = overflow_q;
    assign handshake  = cell_valid && cell_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        row_hi_d  = row_hi_q;
        col_lo_d  = col_lo_q;
        col_hi_d  = col_hi_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty)     state_d = ST_LOAD;
                else if (eof_q) state_d = ST_DONE;
            end
            ST_LOAD: begin
                // Corners may arrive swapped; normalize each axis to lo..hi.
                op_d      = head_op;
                row_cnt_d = (h_sr < h_er) ? h_sr : h_er;
                row_hi_d  = (h_sr < h_er) ? h_er : h_sr;
                col_lo_d  = (h_sc < h_ec) ? h_sc : h_ec;
                col_hi_d  = (h_sc < h_ec) ? h_ec : h_sc;
                col_cnt_d = col_lo_d;
                state_d   = (head_op == 2'b10) ? ST_IDLE : ST_SCAN;
            end
            ST_SCAN: begin
                if (cell_ready) begin
                    if (scan_last) begin
                        state_d = ST_IDLE;
                    end else if (col_cnt_q == col_hi_q) begin
                        col_cnt_d = col_lo_q;
                        row_cnt_d = row_cnt_q + POS_ONE;
                    end else begin
                        col_cnt_d = col_cnt_q + POS_ONE;
                    end
                end
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= normalized_instr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            eof_q      <= 1'b0;
            overflow_q <= 1'b0;
            op_q       <= '0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            row_hi_q   <= '0;
            col_lo_q   <= '0;
            col_hi_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q    <= count_d;
            state_q    <= state_d;
            eof_q      <= eof_q | end_of_file;
            overflow_q <= overflow_q | (normalized_instr_valid && full && !done);
            op_q       <= op_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            row_hi_q   <= row_hi_d;
            col_lo_q   <= col_lo_d;
            col_hi_q   <= col_hi_d;
        end
    end

`ifdef INSTR_SEQ_STATS_EN
    logic [31:0] instr_cnt_q, cell_cnt_q;
    assign instr_count = instr_cnt_q;
    assign cell_count  = cell_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_q <= '0;
            cell_cnt_q  <= '0;
        end else begin
            if (pop && head_op != 2'b10 && instr_cnt_q != '1) instr_cnt_q <= instr_cnt_q + 32'd1;
            if (handshake && cell_cnt_q != '1)                 cell_cnt_q  <= cell_cnt_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer with a cell scoreboard
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        end_of_file;
    logic        normalized_instr_valid;
    logic [49:0] normalized_instr_data;
    logic        cell_valid;
    logic        cell_ready;
    logic [11:0] cell_row;
    logic [11:0] cell_col;
    logic [1:0]  cell_op;
    logic        cell_last;
    logic        done;
    logic        overflow;
`ifdef INSTR_SEQ_STATS_EN
    logic [31:0] instr_count;
    logic [31:0] cell_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [26:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [26:0] prev_cell  = '0;

    instr_sequencer #(.POSITION_WIDTH(12), .INSTRUCTION_WIDTH(50), .FIFO_DEPTH(4)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .end_of_file            (end_of_file),
        .normalized_instr_valid (normalized_instr_valid),
        .normalized_instr_data  (normalized_instr_data),
        .cell_valid             (cell_valid),
        .cell_ready             (cell_ready),
        .cell_row               (cell_row),
        .cell_col               (cell_col),
        .cell_op                (cell_op),
        .cell_last              (cell_last),
        .done                   (done),
        .overflow               (overflow)
`ifdef INSTR_SEQ_STATS_EN
        ,
        .instr_count            (instr_count),
        .cell_count             (cell_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input int sr, input int sc, input int er, input int ec,
                        input logic eof);
        normalized_instr_data  = {op, 12'(sr), 12'(sc), 12'(er), 12'(ec)};
        normalized_instr_valid = 1'b1;
        end_of_file            = eof;
        tick();
        normalized_instr_valid = 1'b0;
        end_of_file            = 1'b0;
    endtask

    // Expected cells of an already-normalized rectangle, row-major.
    task automatic push_cells(input logic [1:0] op, input int r0, input int c0, input int r1, input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                exp_q.push_back({12'(r), 12'(c), op, (r == r1 && c == c1)});
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!cell_valid && n < 20) begin tick(); n++; end
        chk(tag, cell_valid, 1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || cell_valid) && n < 200) begin tick(); n++; end
        chk(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", {cell_valid, cell_row, cell_col, cell_op, cell_last}, {1'b1, prev_cell});
            if (cell_valid && cell_ready) begin
                chk("cell_extra", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    chk("cell", {cell_row, cell_col, cell_op, cell_last}, exp_q.pop_front());
            end
            prev_stall = cell_valid && !cell_ready;
            prev_cell  = {cell_row, cell_col, cell_op, cell_last};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; end_of_file = 1'b0; normalized_instr_valid = 1'b0;
        normalized_instr_data = '0; cell_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_outputs", {cell_valid, cell_last, done, overflow, cell_op}, 0);
        chk("rst_rowcol", {cell_row, cell_col}, 0);

        // single instruction with latency check
        push_cells(2'b11, 0, 0, 1, 2);
        send(2'b11, 0, 0, 1, 2, 1'b0);
        chk("lat_n1", cell_valid, 0);
        tick();
        chk("lat_n2", cell_valid, 0);
        tick();
        chk("lat_n3", cell_valid, 1);
        chk("first_cell", {cell_row, cell_col, cell_last}, {12'd0, 12'd0, 1'b0});
        wait_drain("single_drain");

        // swapped corners
        push_cells(2'b01, 3, 6, 5, 7);
        send(2'b01, 5, 7, 3, 6, 1'b0);
        wait_drain("swap_drain");

        // backpressure pattern 1,0,0,1,0,1
        cell_ready = 1'b0;
        push_cells(2'b00, 2, 2, 2, 4);
        send(2'b00, 2, 2, 2, 4, 1'b0);
        wait_valid("bp_valid");
        begin
            logic [5:0] pat;
            pat = 6'b101001;
            for (int i = 0; i < 6; i++) begin
                cell_ready = pat[i];
                tick();
            end
        end
        cell_ready = 1'b1;
        chk("bp_after", cell_valid, 0);
        wait_drain("bp_drain");

        // overflow: one instruction scanning, four buffered, sixth dropped
        cell_ready = 1'b0;
        push_cells(2'b11, 0, 0, 0, 1);
        send(2'b11, 0, 0, 0, 1, 1'b0);
        wait_valid("ovf_valid");
        for (int k = 1; k <= 4; k++) begin
            push_cells(2'b01, k, 0, k, 1);
            send(2'b01, k, 0, k, 1, 1'b0);
        end
        chk("ovf_before", overflow, 0);
        send(2'b11, 7, 7, 7, 7, 1'b0);
        chk("ovf_after", overflow, 1);
        cell_ready = 1'b1;
        wait_drain("ovf_drain");
        chk("ovf_sticky", overflow, 1);

        // reset while stalled on cell (0,1) of a 2x2 rectangle
        exp_q.push_back({12'd0, 12'd0, 2'b11, 1'b0});
        send(2'b11, 0, 0, 1, 1, 1'b0);
        wait_valid("rst_scan_valid");
        tick();
        cell_ready = 1'b0;
        tick();
        chk("stall_cell", {cell_valid, cell_row, cell_col}, {1'b1, 12'd0, 12'd1});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_outputs", {cell_valid, cell_last, done, overflow, cell_op}, 0);
        chk("midrst_rowcol", {cell_row, cell_col}, 0);
        cell_ready = 1'b1;
        tick(); tick(); tick();
        chk("midrst_empty", cell_valid, 0);
        exp_q.push_back({12'd9, 12'd9, 2'b01, 1'b1});
        send(2'b01, 9, 9, 9, 9, 1'b0);
        wait_valid("single_cell_valid");
        chk("single_cell_last", cell_last, 1);
        wait_drain("single_cell_drain");

        // reserved op together with end of file
        send(2'b10, 1, 1, 2, 2, 1'b1);
        begin
            int n = 0;
            while (!done && n < 4) begin
                chk("eof_novalid", cell_valid, 0);
                tick();
                n++;
            end
        end
        chk("eof_done", done, 1);
        send(2'b11, 1, 1, 1, 1, 1'b0);
        tick(); tick(); tick(); tick();
        chk("post_done_valid", cell_valid, 0);
        chk("post_done_ovf", overflow, 0);
        chk("post_done_sticky", done, 1);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
